pipe_exe_muldiv: RTL and testbench
==================================

# pipe_exe_muldiv

Iterative integer multiply/divide unit for the execute stage. It consumes the operands and decoded op issued by the decode-to-execute pipeline register, and owns the architectural HI/LO registers. It performs MULT/MULTU/DIV/DIVU in a multi-cycle shift-add or restoring-divide loop, performs MTHI/MTLO in one cycle, and raises a stall to decode while a result is outstanding.

## Interface
Parameters:
- `W`, default 32: operand width. HI and LO are each W bits wide.

Ports:
- `clk`, in, 1: clock. All state changes on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: issue qualifier from the E stage. Means a valid mul/div/mt op is in E and `ecancel` is 0.
- `op`, in, 3: operation. 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO. Values 6 and 7 are no-op.
- `a`, in, W: rs operand (`eda`).
- `b`, in, W: rt operand (`edb`).
- `abort`, in, 1: exception or interrupt flush. Kills the in-flight operation.
- `d_hilo`, in, 1: instruction in D reads HI/LO (MFHI/MFLO) or is itself a mul/div/mt op.
- `busy`, out, 1: iterative operation in flight.
- `stall`, out, 1: equals `busy & d_hilo`. Freezes PC and IF/D.
- `done`, out, 1: one-cycle pulse in the cycle after HI/LO are written by a mul/div.
- `hi`, out, W: HI register.
- `lo`, out, W: LO register.

## Operation
States: IDLE, RUN, FIX.

IDLE:
- `start` with op 4: `hi <= a`. With op 5: `lo <= a`. State stays IDLE.
- `start` with op 0–3:
  - Latch `|a|` and `|b|`. Absolute value applies to signed ops only.
  - Latch the result sign (a^b) and the remainder sign (a).
  - Load the iteration counter with W. Go to RUN.

RUN: one iteration per cycle.
- Multiply: 2W-bit shift-add, one multiplier bit per cycle.
- Divide: restoring, one quotient bit per cycle.
- Counter decrements each cycle. When the counter is 1, the next state is FIX.

FIX:
- Apply sign correction.
  - Signed multiply: negate the 2W-bit product if the signs differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the sign of `a`.
- Write `{hi,lo}`: product for multiply; HI=remainder, LO=quotient for divide. Go to IDLE.

Divide by zero: the same latency, forced result HI=`a` (original, unsigned view) and LO=all ones, for both signed and unsigned.

Signed overflow (0x80000000 / -1): LO=0x80000000, HI=0.

`abort` in RUN or FIX: go to IDLE on the next edge with HI/LO unchanged and no `done` pulse. `abort` wins over `start` in the same cycle, so the op is dropped.

`start` while `busy`: ignored. The stall protocol prevents this.

Reset mid-operation: everything returns to reset values immediately.

## Timing
Reset values: `hi`=0, `lo`=0, state IDLE, counter 0, `busy`=0, `stall`=0, `done`=0.

Mul/div issued in cycle T:
- `busy`=1 in cycles T+1 … T+W+1 (W RUN cycles plus one FIX cycle).
- HI/LO are written at the end of cycle T+W+1 and are visible in cycle T+W+2.
- `done`=1 in cycle T+W+2, the same cycle `busy` drops.

MTHI/MTLO issued in T: the value is visible in T+1 and `busy` never rises.

`stall` is combinational from the registered `busy` and the input `d_hilo`. It has no path from `start`.

Back-to-back: a new `start` is accepted in the cycle `busy` is 0, i.e. cycle T+W+2.

## Structure
- Op encodings (the 3-bit codes) and state encodings go in the shared defines header `muldiv_defs.vh`. The decoder includes the same header.
- One sub-module is natural: `muldiv_step`, the combinational single-iteration datapath. It takes the partial remainder/product, the operand and a mode bit, and returns the next partial state plus the quotient bit.
- The FSM, counter, sign handling and the HI/LO registers stay in the top module.

## Test plan
1. MULT a=-3 (0xFFFFFFFD), b=7, start at T. Expect `busy` high for 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB and a `done` pulse at T+34.
2. DIVU a=100, b=7. Expect LO=14, HI=2. Then DIV a=-100, b=7. Expect LO=0xFFFFFFF2 (-14), HI=0xFFFFFFFE (-2).
3. DIV a=5, b=0. Expect HI=5, LO=0xFFFFFFFF with the same latency. Also DIV 0x80000000 / 0xFFFFFFFF. Expect LO=0x80000000, HI=0.
4. MULTU in flight with `d_hilo`=1. Expect `stall`=1 in every busy cycle, and 0 in the cycle `done` rises. MTHI 0x1234 with `busy`=0. Expect `hi`=0x1234 the next cycle.
5. Preload HI=LO=0xAA, then issue DIVU and assert `abort` at RUN cycle 10. Expect IDLE next cycle, HI=LO=0xAA, no `done`. Also `start` and `abort` together: nothing changes.
6. Assert `rst` asynchronously mid-RUN, between clock edges. Expect `busy`, `hi`, `lo` and `done` to go to 0 immediately. After release, a new MULT completes normally.

Source files
------------

// File: rtl/pipe_exe_muldiv_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit.
// The decoder imports the same op codes.
package pipe_exe_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_NOP6  = 3'd6,
    OP_NOP7  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_exe_muldiv_step.sv
// One iteration of the shift-add multiply or restoring divide.
// acc holds {upper, lower}: {partial product, multiplier} or {remainder, dividend/quotient}.
module pipe_exe_muldiv_step #(
  parameter int W = 32
) (
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   opnd,
  input  logic           div,
  output logic [2*W-1:0] nxt,
  output logic           qbit
);

  logic [W:0] sum_s;
  logic [W:0] addend_s;
  logic [W:0] trial_s;

  // Single-iteration datapath, selected by mode
  always_comb begin
    sum_s    = {(W+1){1'b0}};
    addend_s = {(W+1){1'b0}};
    trial_s  = {(W+1){1'b0}};
    nxt      = acc;
    qbit     = 1'b0;
    if (!div) begin
      if (acc[0]) begin
        addend_s = {1'b0, opnd};
      end else begin
        addend_s = {(W+1){1'b0}};
      end
      sum_s = {1'b0, acc[2*W-1:W]} + addend_s;
      nxt   = {sum_s, acc[W-1:1]};
    end else begin
      // Shifted remainder needs W+1 bits; the top bit of trial is the borrow.
      trial_s = acc[2*W-1:W-1] - {1'b0, opnd};
      if (!trial_s[W]) begin
        nxt  = {trial_s[W-1:0], acc[W-2:0], 1'b0};
        qbit = 1'b1;
      end else begin
        nxt  = {acc[2*W-2:0], 1'b0};
        qbit = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_exe_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, with MTHI/MTLO and
// a decode stall while a result is outstanding.
module pipe_exe_muldiv
  import pipe_exe_muldiv_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         abort,
  input  logic         d_hilo,
  output logic         busy,
  output logic         stall,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int CW = $clog2(W + 1);

  state_e         state_r;
  logic [CW-1:0]  cnt_r;
  logic [2*W-1:0] acc_r;
  logic [W-1:0]   opb_r;
  logic [W-1:0]   aorig_r;
  logic           isdiv_r;
  logic           issigned_r;
  logic           rsign_r;
  logic           asign_r;
  logic           dz_r;
  logic           busy_r;
  logic           done_r;
  logic [W-1:0]   hi_r;
  logic [W-1:0]   lo_r;

  op_e            op_s;
  logic           sgn_s;
  logic [W-1:0]   a_abs_s;
  logic [W-1:0]   b_abs_s;
  logic [2*W-1:0] step_nxt_s;
  logic           qbit_s;
  logic [2*W-1:0] acc_nxt_s;
  logic [2*W-1:0] prod_s;
  logic [W-1:0]   quot_s;
  logic [W-1:0]   rem_s;
  logic [W-1:0]   fix_hi_s;
  logic [W-1:0]   fix_lo_s;

  assign op_s  = op_e'(op);
  assign sgn_s = ~op[0];

  // Operand magnitudes at issue; unsigned ops pass straight through
  always_comb begin
    if (sgn_s && a[W-1]) begin
      a_abs_s = -a;
    end else begin
      a_abs_s = a;
    end
    if (sgn_s && b[W-1]) begin
      b_abs_s = -b;
    end else begin
      b_abs_s = b;
    end
  end

  pipe_exe_muldiv_step #(.W(W)) u_step (
    .acc  (acc_r),
    .opnd (opb_r),
    .div  (isdiv_r),
    .nxt  (step_nxt_s),
    .qbit (qbit_s)
  );

  assign acc_nxt_s = step_nxt_s | {{(2*W-1){1'b0}}, qbit_s};

  // Sign correction and divide-by-zero override for the FIX write
  always_comb begin
    if (issigned_r && rsign_r) begin
      prod_s = -acc_r;
      quot_s = -acc_r[W-1:0];
    end else begin
      prod_s = acc_r;
      quot_s = acc_r[W-1:0];
    end
    if (issigned_r && asign_r) begin
      rem_s = -acc_r[2*W-1:W];
    end else begin
      rem_s = acc_r[2*W-1:W];
    end
    if (!isdiv_r) begin
      fix_hi_s = prod_s[2*W-1:W];
      fix_lo_s = prod_s[W-1:0];
    end else if (dz_r) begin
      fix_hi_s = aorig_r;
      fix_lo_s = {W{1'b1}};
    end else begin
      fix_hi_s = rem_s;
      fix_lo_s = quot_s;
    end
  end

  // Control FSM, iteration counter, datapath state and HI/LO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CW{1'b0}};
      acc_r      <= {(2*W){1'b0}};
      opb_r      <= {W{1'b0}};
      aorig_r    <= {W{1'b0}};
      isdiv_r    <= 1'b0;
      issigned_r <= 1'b0;
      rsign_r    <= 1'b0;
      asign_r    <= 1'b0;
      dz_r       <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      hi_r       <= {W{1'b0}};
      lo_r       <= {W{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // abort dominates start, so a flushed issue is simply dropped
          if (start && !abort) begin
            case (op_s)
              OP_MTHI: hi_r <= a;
              OP_MTLO: lo_r <= a;
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                acc_r      <= {{W{1'b0}}, a_abs_s};
                opb_r      <= b_abs_s;
                aorig_r    <= a;
                isdiv_r    <= op[1];
                issigned_r <= sgn_s;
                rsign_r    <= a[W-1] ^ b[W-1];
                asign_r    <= a[W-1];
                dz_r       <= (b == {W{1'b0}});
                cnt_r      <= CW'(W);
                busy_r     <= 1'b1;
                state_r    <= ST_RUN;
              end
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (abort) begin
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            acc_r <= acc_nxt_s;
            cnt_r <= cnt_r - CW'(1);
            if (cnt_r == CW'(1)) begin
              state_r <= ST_FIX;
            end
          end
        end
        ST_FIX: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
          if (!abort) begin
            hi_r   <= fix_hi_s;
            lo_r   <= fix_lo_s;
            done_r <= 1'b1;
          end
        end
        default: begin
          cnt_r   <= {CW{1'b0}};
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_r;
  assign stall = busy_r & d_hilo;
  assign done  = done_r;
  assign hi    = hi_r;
  assign lo    = lo_r;

endmodule

// File: tb/tb_pipe_exe_muldiv.sv
// Directed self-checking bench for pipe_exe_muldiv (W=32).
module tb_pipe_exe_muldiv;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        abort;
  logic        d_hilo;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int pass_cnt;
  int total_cnt;

  pipe_exe_muldiv #(.W(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .abort  (abort),
    .d_hilo (d_hilo),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called just after a negedge; returns at the negedge after the issue edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 3'd7; a = 32'd0; b = 32'd0;
  endtask

  // Issue a mul/div and follow it until busy drops (bounded).
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int nb, output int stall_err, output int early_done);
    nb = 0; stall_err = 0; early_done = 0;
    issue(o, x, y);
    for (int i = 0; i < 60; i++) begin
      if (!busy) break;
      nb++;
      if (stall !== d_hilo) stall_err++;
      if (done !== 1'b0) early_done++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    if ({busy, stall, done, hi, lo} !== 67'd0) begin
      $display("FAIL reset: busy=%b stall=%b done=%b hi=%h lo=%h, want all 0", busy, stall, done, hi, lo);
    end else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_mult;
    int nb, se, ed;
    run_op(3'd0, 32'hFFFFFFFD, 32'd7, nb, se, ed);
    if (nb !== 33 || ed !== 0) begin
      $display("FAIL mult_latency: busy_cycles=%0d early_done=%0d, want 33/0", nb, ed);
    end else pass_cnt++;
    total_cnt++;
    if (done !== 1'b1 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
      $display("FAIL mult_result: done=%b hi=%h lo=%h, want 1 ffffffff ffffffeb", done, hi, lo);
    end else pass_cnt++;
    total_cnt++;
    @(negedge clk);
    if (done !== 1'b0) begin
      $display("FAIL mult_done_pulse: done=%b, want 0", done);
    end else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_div;
    int nb, se, ed;
    run_op(3'd3, 32'd100, 32'd7, nb, se, ed);
    if (done !== 1'b1 || hi !== 32'd2 || lo !== 32'd14) begin
      $display("FAIL divu: done=%b hi=%h lo=%h, want 1 00000002 0000000e", done, hi, lo);
    end else pass_cnt++;
    total_cnt++;
    @(negedge clk);
    run_op(3'd2, 32'hFFFFFF9C, 32'd7, nb, se, ed);
    if (nb !== 33 || hi !== 32'hFFFFFFFE || lo !== 32'hFFFFFFF2) begin
      $display("FAIL div_signed: busy_cycles=%0d hi=%h lo=%h, want 33 fffffffe fffffff2", nb, hi, lo);
    end else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_div_boundary;
    int nb, se, ed;
    @(negedge clk);
    run_op(3'd2, 32'd5, 32'd0, nb, se, ed);
    if (nb !== 33 || done !== 1'b1 || hi !== 32'd5 || lo !== 32'hFFFFFFFF) begin
      $display("FAIL div_by_zero: busy_cycles=%0d done=%b hi=%h lo=%h, want 33 1 00000005 ffffffff", nb, done, hi, lo);
    end else pass_cnt++;
    total_cnt++;
    @(negedge clk);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, nb, se, ed);
    if (hi !== 32'd0 || lo !== 32'h80000000) begin
      $display("FAIL div_overflow: hi=%h lo=%h, want 00000000 80000000", hi, lo);
    end else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_stall_mt;
    int nb, se, ed;
    @(negedge clk);
    d_hilo = 1'b1;
    run_op(3'd1, 32'hFFFFFFFF, 32'd2, nb, se, ed);
    if (nb !== 33 || se !== 0) begin
      $display("FAIL stall_busy: busy_cycles=%0d stall_errors=%0d, want 33/0", nb, se);
    end else pass_cnt++;
    total_cnt++;
    if (done !== 1'b1 || stall !== 1'b0 || hi !== 32'd1 || lo !== 32'hFFFFFFFE) begin
      $display("FAIL stall_done: done=%b stall=%b hi=%h lo=%h, want 1 0 00000001 fffffffe", done, stall, hi, lo);
    end else pass_cnt++;
    total_cnt++;
    d_hilo = 1'b0;
    @(negedge clk);
    issue(3'd4, 32'h00001234, 32'd0);
    if (hi !== 32'h00001234 || busy !== 1'b0 || lo !== 32'hFFFFFFFE) begin
      $display("FAIL mthi: hi=%h busy=%b lo=%h, want 00001234 0 fffffffe", hi, busy, lo);
    end else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_back_to_back;
    int nb, se, ed;
    @(negedge clk);
    run_op(3'd1, 32'd3, 32'd5, nb, se, ed);
    run_op(3'd3, 32'd50, 32'd8, nb, se, ed);
    if (nb !== 33 || hi !== 32'd2 || lo !== 32'd6) begin
      $display("FAIL back_to_back: busy_cycles=%0d hi=%h lo=%h, want 33 00000002 00000006", nb, hi, lo);
    end else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_abort;
    int done_seen;
    @(negedge clk);
    issue(3'd4, 32'h000000AA, 32'd0);
    issue(3'd5, 32'h000000AA, 32'd0);
    issue(3'd3, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    if (busy !== 1'b0 || hi !== 32'h000000AA || lo !== 32'h000000AA) begin
      $display("FAIL abort_run: busy=%b hi=%h lo=%h, want 0 000000aa 000000aa", busy, hi, lo);
    end else pass_cnt++;
    total_cnt++;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) done_seen++;
      @(negedge clk);
    end
    if (done_seen !== 0 || hi !== 32'h000000AA) begin
      $display("FAIL abort_quiet: done_or_busy_cycles=%0d hi=%h, want 0 000000aa", done_seen, hi);
    end else pass_cnt++;
    total_cnt++;
    abort = 1'b1;
    issue(3'd4, 32'h00000055, 32'd0);
    issue(3'd0, 32'd9, 32'd9);
    abort = 1'b0;
    if (busy !== 1'b0 || hi !== 32'h000000AA || lo !== 32'h000000AA) begin
      $display("FAIL start_with_abort: busy=%b hi=%h lo=%h, want 0 000000aa 000000aa", busy, hi, lo);
    end else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_async_reset;
    int nb, se, ed;
    @(negedge clk);
    issue(3'd0, 32'd11, 32'd13);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h, want 0 0 0 0", busy, done, hi, lo);
    end else pass_cnt++;
    total_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(3'd0, 32'd6, 32'hFFFFFFF9, nb, se, ed);
    if (nb !== 33 || done !== 1'b1 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFD6) begin
      $display("FAIL after_reset_mult: busy_cycles=%0d done=%b hi=%h lo=%h, want 33 1 ffffffff ffffffd6", nb, done, hi, lo);
    end else pass_cnt++;
    total_cnt++;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    rst = 1'b1; start = 1'b0; op = 3'd7; a = 32'd0; b = 32'd0;
    abort = 1'b0; d_hilo = 1'b0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_mult();
    test_div();
    test_div_boundary();
    test_stall_mt();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
